// File: rtl/control_multi_hs.sv
// Multicycle RV32I control FSM with req/ready memory handshake, watchdog and retire counter.
// Optional feature: define CTRL_TRAP_EN to divert faults to a one-cycle TRAP state instead of sticky ERRO.
module control_multi_hs #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [6:0]       iOp,
  input  logic [2:0]       iFunct3,
  input  logic [6:0]       iFunct7,
  input  logic             iMemReady,
  output logic             oMemReq,
  output logic             oIRWrite,
  output logic             oPCWrite,
  output logic             oPCWriteCond,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oMemtoReg,
  output logic             oRegWrite,
  output logic [1:0]       oALUSrcA,
  output logic [2:0]       oALUSrcB,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oPCSource,
  output logic [5:0]       oState,
  output logic             oRetire,
  output logic [CNT_W-1:0] oInstrCnt,
  output logic             oErr
);

  typedef enum logic [5:0] {
    S_FETCH    = 6'd0,
    S_DECODE   = 6'd1,
    S_EX_R     = 6'd2,
    S_EX_I     = 6'd3,
    S_MEM_ADDR = 6'd4,
    S_MEM_RD   = 6'd5,
    S_MEM_WB   = 6'd6,
    S_MEM_WR   = 6'd7,
    S_BRANCH   = 6'd8,
    S_JAL      = 6'd9,
    S_JALR     = 6'd10,
    S_LUI      = 6'd11,
    S_AUIPC    = 6'd12,
    S_ALU_WB   = 6'd13,
`ifdef CTRL_TRAP_EN
    S_TRAP     = 6'd62,
`endif
    S_ERRO     = 6'd63
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

`ifdef CTRL_TRAP_EN
  localparam state_e ERR_TGT = S_TRAP;
`else
  localparam state_e ERR_TGT = S_ERRO;
`endif

  localparam bit          WD_EN  = (TIMEOUT_CYC != 0);
  localparam int unsigned WD_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q;
  logic             link_q, link_d;
  logic             mem_req;
  logic             timeout;

  // funct3 selects the ALU operation inside the datapath's ALU control, not here.
  logic unused_funct3;
  assign unused_funct3 = ^iFunct3;

  assign mem_req = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = WD_EN && mem_req && !iMemReady && (wd_q == WD_LIM);

  // Reset must withdraw the request at once, without waiting for a clock edge.
  assign oMemReq   = mem_req & iRST_N;
  assign oState    = state_q;
  assign oInstrCnt = cnt_q;

  always_comb begin
    wd_d = '0;
    if (WD_EN && mem_req && !iMemReady) wd_d = wd_q + WD_W'(1);
    // Link writeback (rd <- oldPC+4) happens in the ALU_WB cycle right after JAL/JALR.
    link_d = (state_q == S_JAL) || (state_q == S_JALR);
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path can infer a latch.
    state_d      = state_q;
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oMemtoReg    = 1'b0;
    oRegWrite    = 1'b0;
    oALUSrcA     = 2'd0;
    oALUSrcB     = 3'd0;
    oALUOp       = 2'd0;
    oPCSource    = 2'd0;
    oRetire      = 1'b0;
    oErr         = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        oMemRead = 1'b1;
        oALUSrcB = 3'd1;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d  = ERR_TGT;
        end
      end

      S_DECODE: begin
        oALUSrcA = 2'd2;
        oALUSrcB = 3'd3;
        case (iOp)
          OP_R:               state_d = S_EX_R;
          OP_IMM:             state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          default:            state_d = ERR_TGT;
        endcase
      end

      S_EX_R: begin
        oALUSrcA = 2'd1;
        oALUOp   = 2'd2;
        if (iFunct7 == 7'h00 || iFunct7 == 7'h20) state_d = S_ALU_WB;
        else                                      state_d = ERR_TGT;
      end

      S_EX_I: begin
        oALUSrcA = 2'd1;
        oALUSrcB = 3'd2;
        oALUOp   = 2'd2;
        state_d  = S_ALU_WB;
      end

      S_ALU_WB: begin
        oRegWrite = 1'b1;
        oRetire   = 1'b1;
        if (link_q) begin
          oALUSrcA = 2'd2;
          oALUSrcB = 3'd1;
        end
        state_d = S_FETCH;
      end

      S_MEM_ADDR: begin
        oALUSrcA = 2'd1;
        oALUSrcB = 3'd2;
        state_d  = (iOp == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
        if (iMemReady)    state_d = S_MEM_WB;
        else if (timeout) state_d = ERR_TGT;
      end

      S_MEM_WB: begin
        oRegWrite = 1'b1;
        oMemtoReg = 1'b1;
        oRetire   = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEM_WR: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        if (iMemReady) begin
          oRetire = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = ERR_TGT;
        end
      end

      S_BRANCH: begin
        oALUSrcA     = 2'd1;
        oALUOp       = 2'd1;
        oPCWriteCond = 1'b1;
        oPCSource    = 2'd1;
        oRetire      = 1'b1;
        state_d      = S_FETCH;
      end

      S_JAL: begin
        oPCWrite  = 1'b1;
        oPCSource = 2'd1;
        state_d   = S_ALU_WB;
      end

      S_JALR: begin
        oALUSrcA  = 2'd1;
        oALUSrcB  = 3'd2;
        oPCWrite  = 1'b1;
        oPCSource = 2'd2;
        state_d   = S_ALU_WB;
      end

      S_LUI: begin
        // ALUOp 3 passes operand B through, giving the bare upper immediate.
        oALUSrcB = 3'd4;
        oALUOp   = 2'd3;
        state_d  = S_ALU_WB;
      end

      S_AUIPC: begin
        oALUSrcA = 2'd2;
        oALUSrcB = 3'd4;
        state_d  = S_ALU_WB;
      end

`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        oErr      = 1'b1;
        oPCWrite  = 1'b1;
        oPCSource = 2'd3;
        state_d   = S_FETCH;
      end
`endif

      S_ERRO: begin
        oErr = 1'b1;
      end

      default: state_d = S_ERRO;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
      cnt_q   <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      link_q  <= link_d;
      if (oRetire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_multi_hs.sv
// Directed self-checking bench for control_multi_hs: instruction classes, handshake waits,
// watchdog timeout, reset mid-access and retire-counter wrap.
module tb_control_multi_hs;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic       clk, rst_n;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       ready;

  logic       req, irw, pcw, pcwc, iord, mrd, mwr, m2r, rw, ret, err;
  logic [1:0] srca, aluop, pcsrc;
  logic [2:0] srcb;
  logic [5:0] st;
  logic [3:0] cnt;

  logic        req0, irw0, pcw0, pcwc0, iord0, mrd0, mwr0, m2r0, rw0, ret0, err0;
  logic [1:0]  srca0, aluop0, pcsrc0;
  logic [2:0]  srcb0;
  logic [5:0]  st0;
  logic [31:0] cnt0;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  control_multi_hs #(.TIMEOUT_CYC(16), .CNT_W(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iOp(op), .iFunct3(f3), .iFunct7(f7), .iMemReady(ready),
    .oMemReq(req), .oIRWrite(irw), .oPCWrite(pcw), .oPCWriteCond(pcwc), .oIorD(iord),
    .oMemRead(mrd), .oMemWrite(mwr), .oMemtoReg(m2r), .oRegWrite(rw),
    .oALUSrcA(srca), .oALUSrcB(srcb), .oALUOp(aluop), .oPCSource(pcsrc),
    .oState(st), .oRetire(ret), .oInstrCnt(cnt), .oErr(err)
  );

  control_multi_hs #(.TIMEOUT_CYC(0), .CNT_W(32)) dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iOp(op), .iFunct3(f3), .iFunct7(f7), .iMemReady(ready),
    .oMemReq(req0), .oIRWrite(irw0), .oPCWrite(pcw0), .oPCWriteCond(pcwc0), .oIorD(iord0),
    .oMemRead(mrd0), .oMemWrite(mwr0), .oMemtoReg(m2r0), .oRegWrite(rw0),
    .oALUSrcA(srca0), .oALUSrcB(srcb0), .oALUOp(aluop0), .oPCSource(pcsrc0),
    .oState(st0), .oRetire(ret0), .oInstrCnt(cnt0), .oErr(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  int t0;
  int req_cyc;

  initial begin
    rst_n = 1'b0; op = OP_R; f3 = 3'd0; f7 = 7'h00; ready = 1'b0;
    #3;
    check("rst_state", st, 0);
    check("rst_req", req, 0);
    check("rst_cnt", cnt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("fetch_req", req, 1);
    check("fetch_irw_noready", irw, 0);

    // add x3,x1,x2
    ready = 1'b1; op = OP_R; f7 = 7'h00;
    #1;
    check("add0_state", st, 0);
    check("add0_irw", irw, 1);
    check("add0_pcw", pcw, 1);
    check("add0_rw", rw, 0);
    tick();
    check("add1_state", st, 1);
    check("add1_srca", srca, 2);
    check("add1_srcb", srcb, 3);
    check("add1_rw", rw, 0);
    tick();
    check("add2_state", st, 2);
    check("add2_aluop", aluop, 2);
    check("add2_rw", rw, 0);
    tick();
    check("add3_state", st, 13);
    check("add3_rw", rw, 1);
    check("add3_ret", ret, 1);
    check("add3_m2r", m2r, 0);
    tick();
    check("add4_state", st, 0);
    check("add4_ret", ret, 0);
    check("add_cnt", cnt, 1);

    // lw with 5 wait cycles in MEM_RD
    op = OP_LOAD;
    t0 = cyc;
    req_cyc = 0;
    tick();
    tick();
    check("lw_maddr_state", st, 4);
    check("lw_maddr_srca", srca, 1);
    check("lw_maddr_srcb", srcb, 2);
    ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (st == 6'd5 && req) req_cyc++;
      tick();
    end
    ready = 1'b1;
    #1;
    if (st == 6'd5 && req) req_cyc++;
    check("lw_rd_state", st, 5);
    check("lw_rd_iord", iord, 1);
    tick();
    check("lw_wb_state", st, 6);
    check("lw_wb_rw", rw, 1);
    check("lw_wb_m2r", m2r, 1);
    check("lw_wb_ret", ret, 1);
    tick();
    check("lw_req_cycles", req_cyc, 6);
    check("lw_latency", cyc - t0, 10);
    check("lw_back_fetch", st, 0);
    check("lw_cnt", cnt, 2);

    // store
    op = OP_STORE;
    tick();
    tick();
    tick();
    ready = 1'b0;
    #1;
    check("sw_state", st, 7);
    check("sw_mwr", mwr, 1);
    check("sw_ret_wait", ret, 0);
    ready = 1'b1;
    #1;
    check("sw_ret_ready", ret, 1);
    tick();
    check("sw_cnt", cnt, 3);

    // branch
    op = OP_BRANCH;
    tick();
    tick();
    check("br_state", st, 8);
    check("br_pcwc", pcwc, 1);
    check("br_pcsrc", pcsrc, 1);
    check("br_aluop", aluop, 1);
    check("br_ret", ret, 1);
    tick();
    check("br_cnt", cnt, 4);

    // jalr
    op = OP_JALR;
    tick();
    tick();
    check("jalr1_state", st, 10);
    check("jalr1_pcw", pcw, 1);
    check("jalr1_pcsrc", pcsrc, 2);
    check("jalr1_ret", ret, 0);
    tick();
    check("jalr2_state", st, 13);
    check("jalr2_srca", srca, 2);
    check("jalr2_srcb", srcb, 1);
    check("jalr2_ret", ret, 1);
    tick();
    check("jalr_cnt", cnt, 5);

    // illegal opcode
    op = 7'h7F;
    tick();
    tick();
`ifdef CTRL_TRAP_EN
    check("ill_state", st, 62);
    check("ill_err", err, 1);
    check("ill_pcw", pcw, 1);
    check("ill_pcsrc", pcsrc, 3);
    tick();
    check("ill_back_fetch", st, 0);
    check("ill_err_pulse", err, 0);
    check("ill_cnt", cnt, 5);
`else
    check("ill_state", st, 63);
    check("ill_err", err, 1);
    check("ill_req", req, 0);
    check("ill_pcw", pcw, 0);
    tick();
    check("ill_sticky", st, 63);
    check("ill_err_held", err, 1);
`endif

    // reset mid-MEM_RD
    reset_pulse();
    op = OP_LOAD; ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    tick();
    check("mrd_state", st, 5);
    check("mrd_req", req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrd_rst_state", st, 0);
    check("mrd_rst_req", req, 0);
    check("mrd_rst_cnt", cnt, 0);
    tick();
    check("mrd_rst_req_held", req, 0);
    rst_n = 1'b1;
    #1;

    // fetch watchdog timeout
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("to_pre_state", st, 0);
      tick();
    end
`ifdef CTRL_TRAP_EN
    check("to_state", st, 62);
    check("to_err", err, 1);
`else
    check("to_state", st, 63);
    check("to_err", err, 1);
`endif
    check("to_nowd_state", st0, 0);
    for (int i = 0; i < 5; i++) tick();
`ifndef CTRL_TRAP_EN
    check("to_sticky", st, 63);
    check("to_err_held", err, 1);
`endif
    check("to_nowd_still", st0, 0);
    check("to_nowd_req", req0, 1);

    // ready on the timeout cycle wins
    reset_pulse();
    op = OP_R; f7 = 7'h20;
    for (int i = 0; i < 15; i++) tick();
    ready = 1'b1;
    #1;
    check("win_state", st, 0);
    check("win_irw", irw, 1);
    tick();
    check("win_decode", st, 1);
    tick();
    tick();
    tick();
    check("win_cnt", cnt, 1);

    // illegal funct7
    f7 = 7'h01;
    tick();
    tick();
    tick();
`ifdef CTRL_TRAP_EN
    check("f7_state", st, 62);
`else
    check("f7_state", st, 63);
`endif

    // retire counter wrap (CNT_W=4)
    reset_pulse();
    op = OP_IMM; f7 = 7'h00; ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      tick();
      tick();
      if (n == 0) check("wrap_exi_state", st, 3);
      tick();
      tick();
    end
    check("wrap_cnt15", cnt, 15);
    for (int i = 0; i < 4; i++) tick();
    check("wrap_cnt0", cnt, 0);
    check("wrap_cnt32", cnt0, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
